// File: rtl/decoder_scan_seq_if.sv
// Bus bundle for decoder_scan_seq: control/select inputs and decoded outputs.
// The slave modport is the decoder side; the master modport is whoever drives it.
interface decoder_scan_seq_if #(
    parameter int N = 3
);
    logic               enable;
    logic               mode;
    logic               load;
    logic               dir;
    logic [N-1:0]       in;
    logic [N-1:0]       sel;
    logic [(1<<N)-1:0]  out;
    logic               wrap;

    modport master (
        output enable, mode, load, dir, in,
        input  sel, out, wrap
    );

    modport slave (
        input  enable, mode, load, dir, in,
        output sel, out, wrap
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode that
// steps the select up or down once every DIV enabled cycles, pulsing wrap when
// the select rolls over between 2^N-1 and 0.
module decoder_scan_seq #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    decoder_scan_seq_if.slave bus
);
    localparam int              W          = 1 << N;
    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [N-1:0]    SEL_MAX    = '1;

    logic [N-1:0]  sel_q,   sel_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          wrap_q,  wrap_d;
    logic [W-1:0]  out_q,   out_d;
    logic          mode_q,  mode_d;

    logic mode_change;
    logic step_due;

    // A mode edge is only acted on while enabled, so a change made while the
    // block is frozen is still seen on the first enabled cycle.
    assign mode_change = (bus.mode != mode_q);
    assign step_due    = (presc_q == PRESC_LAST);
    assign mode_d      = bus.enable ? bus.mode : mode_q;

    // Next select, prescaler and wrap: load beats a step, DIRECT parks the prescaler.
    always_comb begin
        sel_d   = sel_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        if (bus.enable) begin
            if (bus.load) begin
                sel_d   = bus.in;
                presc_d = '0;
            end else if (!bus.mode || mode_change) begin
                presc_d = '0;
            end else if (step_due) begin
                presc_d = '0;
                if (bus.dir) begin
                    sel_d  = sel_q - N'(1);
                    wrap_d = (sel_q == '0);
                end else begin
                    sel_d  = sel_q + N'(1);
                    wrap_d = (sel_q == SEL_MAX);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Decode the next select so out lines up with sel; enable gates every line.
    for (genvar gi = 0; gi < W; gi++) begin : g_dec
        assign out_d[gi] = bus.enable && (sel_d == N'(gi));
    end

    // State registers; reset samples the current mode so no edge is seen on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
            out_q   <= '0;
            mode_q  <= bus.mode;
        end else begin
            sel_q   <= sel_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: DUT a uses DIV=4, DUT b uses DIV=1.
// Each tick pushes the expected post-edge state, then pops and compares it.
module tb_decoder_scan_seq;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    decoder_scan_seq_if #(.N(3)) bus_a ();
    decoder_scan_seq_if #(.N(3)) bus_b ();

    decoder_scan_seq #(.N(3), .DIV(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    decoder_scan_seq #(.N(3), .DIV(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        bit         on_b;
        logic [2:0] sel;
        logic [7:0] out;
        logic       wrap;
    } exp_t;

    exp_t  sb[$];
    string tags[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic md, input logic ld,
                         input logic dr, input logic [2:0] v);
        bus_a.enable = en; bus_a.mode = md; bus_a.load = ld; bus_a.dir = dr; bus_a.in = v;
        bus_b.enable = en; bus_b.mode = md; bus_b.load = ld; bus_b.dir = dr; bus_b.in = v;
    endtask

    // One clock: record the expectation, let the edge happen, compare.
    task automatic tick(input string tag, input bit on_b, input logic [2:0] s,
                        input logic [7:0] o, input logic w);
        exp_t       e;
        string      t;
        logic [2:0] gs;
        logic [7:0] go;
        logic       gw;
        sb.push_back('{on_b: on_b, sel: s, out: o, wrap: w});
        tags.push_back(tag);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        t  = tags.pop_front();
        gs = e.on_b ? bus_b.sel  : bus_a.sel;
        go = e.on_b ? bus_b.out  : bus_a.out;
        gw = e.on_b ? bus_b.wrap : bus_a.wrap;
        $display("tick %-10s dut=%s sel=%0d out=%02h wrap=%0b", t, e.on_b ? "b" : "a", gs, go, gw);
        chk({t, "_sel"},  32'(gs), 32'(e.sel));
        chk({t, "_out"},  32'(go), 32'(e.out));
        chk({t, "_wrap"}, 32'(gw), 32'(e.wrap));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;

        // Reset, then idle disabled
        tick("rst0",   0, 3'd0, 8'h00, 1'b0);
        tick("rst1",   1, 3'd0, 8'h00, 1'b0);
        reset = 1'b0;
        tick("idle",   0, 3'd0, 8'h00, 1'b0);

        // DIRECT load, disable (load ignored), re-enable
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
        tick("dload",  0, 3'd5, 8'h20, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
        tick("dis",    0, 3'd5, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        tick("reen",   0, 3'd5, 8'h20, 1'b0);

        // SCAN up from 6: step every 4 cycles, wrap on 7->0
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6);
        tick("sload",  0, 3'd6, 8'h40, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) tick("up_hold6", 0, 3'd6, 8'h40, 1'b0);
        tick("up_s7",  0, 3'd7, 8'h80, 1'b0);
        for (int i = 0; i < 3; i++) tick("up_hold7", 0, 3'd7, 8'h80, 1'b0);
        tick("up_wrap", 0, 3'd0, 8'h01, 1'b1);
        tick("up_post", 0, 3'd0, 8'h01, 1'b0);

        // Direction flips mid-count: prescaler keeps going, wraps 0->7
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        tick("dn_h0",  0, 3'd0, 8'h01, 1'b0);
        tick("dn_h1",  0, 3'd0, 8'h01, 1'b0);
        tick("dn_wrap", 0, 3'd7, 8'h80, 1'b1);

        // Load coincident with a due step: load wins, next step 4 cycles on
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) tick("pre_ld", 0, 3'd7, 8'h80, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        tick("ld_step", 0, 3'd2, 8'h04, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) tick("ld_hold", 0, 3'd2, 8'h04, 1'b0);
        tick("ld_s3",  0, 3'd3, 8'h08, 1'b0);

        // Reset mid-scan at sel=4, then first step 4 cycles after release
        for (int i = 0; i < 3; i++) tick("to4_hold", 0, 3'd3, 8'h08, 1'b0);
        tick("at4",    0, 3'd4, 8'h10, 1'b0);
        tick("at4_h",  0, 3'd4, 8'h10, 1'b0);
        reset = 1'b1;
        tick("mrst",   0, 3'd0, 8'h00, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("post_rst", 0, 3'd0, 8'h01, 1'b0);
        tick("rst_s1", 0, 3'd1, 8'h02, 1'b0);

        // DIV=1 down from 0: step every cycle, wrap on 0->7
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        tick("b_load", 1, 3'd0, 8'h01, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        tick("b_wrap", 1, 3'd7, 8'h80, 1'b1);
        tick("b_s6",   1, 3'd6, 8'h40, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
